// File: rtl/fib_req_arbiter.sv
// fib_req_arbiter: round-robin front end sharing one Fibonacci engine
// among N_REQ clients; each job resets, starts and awaits the engine.
module fib_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] ReqNum,
  output logic [N_REQ-1:0]       Ack,
  output logic [N_REQ-1:0]       Grant,
  output logic [WIDTH-1:0]       RespResult,
  output logic                   RespErr,
  output logic                   Busy,
  output logic                   EngRst,
  output logic                   EngStart,
  output logic [WIDTH-1:0]       EngNumber,
  input  logic [WIDTH-1:0]       EngResult,
  input  logic                   EngDone
);

  localparam int SW = $clog2(N_REQ);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t        state;
  logic [SW-1:0] sel;
  logic [SW-1:0] last;
  logic [SW-1:0] win;
  logic [SW-1:0] cand;
  logic [SW:0]   nxt;
  logic          found;
  logic [7:0]    cnt;

  // first set request scanning upward from last+1, wrapping
  always_comb begin
    win   = '0;
    found = 1'b0;
    nxt   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      nxt = {1'b0, last} + (SW+1)'(i + 1);
      if (nxt >= (SW+1)'(N_REQ))
        nxt = nxt - (SW+1)'(N_REQ);
      cand = nxt[SW-1:0];
      if (!found && Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      sel        <= '0;
      last       <= SW'(N_REQ - 1);
      cnt        <= '0;
      Ack        <= '0;
      Grant      <= '0;
      RespResult <= '0;
      RespErr    <= 1'b0;
      Busy       <= 1'b0;
      EngRst     <= 1'b1;
      EngStart   <= 1'b0;
      EngNumber  <= '0;
    end else begin
      Ack      <= '0;
      EngRst   <= 1'b0;
      EngStart <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sel       <= win;
            Grant     <= N_REQ'(1) << win;
            EngNumber <= ReqNum[int'(win)*WIDTH +: WIDTH];
            Busy      <= 1'b1;
            EngRst    <= 1'b1;
            state     <= CLR;
          end
        end
        CLR: begin
          EngStart <= 1'b1;
          state    <= START;
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Done takes priority over a timeout in the same cycle
          if (EngDone) begin
            RespResult <= EngResult;
            RespErr    <= 1'b0;
            Ack        <= Grant;
            state      <= RESP;
          end else if (cnt == TO_LAST) begin
            RespResult <= '0;
            RespErr    <= 1'b1;
            Ack        <= Grant;
            state      <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          last  <= sel;
          Grant <= '0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Grant <= '0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_req_arbiter.sv
// tb_fib_req_arbiter: directed vectors plus corner sequences against
// a behavioural Fibonacci engine with a latched Done.
module tb_fib_req_arbiter;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int TO = 16;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [N-1:0] Req;
  logic [N*W-1:0] ReqNum;
  logic [N-1:0] Ack;
  logic [N-1:0] Grant;
  logic [W-1:0] RespResult;
  logic         RespErr;
  logic         Busy;
  logic         EngRst;
  logic         EngStart;
  logic [W-1:0] EngNumber;
  logic [W-1:0] EngResult = '0;
  logic         EngDone = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit never_done = 0;
  int eng_lat = 3;
  int eng_cnt = 0;
  logic [W-1:0] eng_num = '0;
  bit mon_en = 0;

  typedef struct {
    int idx;
    int num;
    bit nd;
    int res;
    int err;
    int lat;
  } vec_t;

  vec_t tbl[7];

  fib_req_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .ReqNum(ReqNum),
    .Ack(Ack), .Grant(Grant), .RespResult(RespResult),
    .RespErr(RespErr), .Busy(Busy), .EngRst(EngRst),
    .EngStart(EngStart), .EngNumber(EngNumber),
    .EngResult(EngResult), .EngDone(EngDone)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int fib_le(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    while (b <= n) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // engine model: Done stays high until the engine is reset
  always @(posedge Clk) begin
    if (EngRst) begin
      EngDone   <= 1'b0;
      EngResult <= '0;
      eng_cnt   <= 0;
    end else if (EngStart) begin
      eng_cnt <= eng_lat;
      eng_num <= EngNumber;
    end else if (eng_cnt == 1) begin
      eng_cnt <= 0;
      if (!never_done) begin
        EngDone   <= 1'b1;
        EngResult <= W'(fib_le(int'(eng_num)));
      end
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (EngStart) start_cyc = cyc;
    if (mon_en && !Rst) begin
      check("grant_onehot0", int'($onehot0(Grant)), 1);
      check("busy_vs_grant", int'(Busy), int'(Grant != '0));
      if (Ack != '0) check("ack_eq_grant", int'(Ack), int'(Grant));
    end
  end

  task automatic wait_ack(output logic [N-1:0] a, output int res,
                          output int err, output int lat);
    a = '0;
    res = -1;
    err = -1;
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge Clk);
      if (Ack != '0) begin
        a = Ack;
        res = int'(RespResult);
        err = int'(RespErr);
        lat = cyc - start_cyc;
        return;
      end
    end
    check("ack_wait_expired", 0, 1);
  endtask

  initial begin
    logic [N-1:0] a;
    int res, err, lat, nack;
    int exp_a[4];
    int exp_c[6];

    tbl[0] = '{0,   10, 0,   8, 0,  5};
    tbl[1] = '{0,  100, 0,  89, 0,  5};
    tbl[2] = '{0,    0, 0,   0, 0,  5};
    tbl[3] = '{1,   20, 0,  13, 0,  5};
    tbl[4] = '{3, 1000, 0, 987, 0,  5};
    tbl[5] = '{2,   50, 1,   0, 1, 17};
    tbl[6] = '{2,   50, 0,  34, 0,  5};
    exp_a = '{8, 13, 34, 89};
    exp_c = '{2, 0, 2, 0, 2, 0};

    Rst = 1'b1;
    Req = '0;
    ReqNum = '0;
    repeat (3) @(negedge Clk);
    check("rst_ack", int'(Ack), 0);
    check("rst_grant", int'(Grant), 0);
    check("rst_result", int'(RespResult), 0);
    check("rst_err", int'(RespErr), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_engstart", int'(EngStart), 0);
    check("rst_engnum", int'(EngNumber), 0);
    check("rst_engrst", int'(EngRst), 1);
    Rst = 1'b0;
    @(negedge Clk);
    check("post_rst_engrst", int'(EngRst), 0);
    mon_en = 1;

    // all four at once: round-robin from requester 0
    ReqNum = {10'd100, 10'd50, 10'd20, 10'd10};
    Req = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      wait_ack(a, res, err, lat);
      check($sformatf("all4_ack%0d", j), int'(a), 1 << j);
      check($sformatf("all4_res%0d", j), res, exp_a[j]);
      check($sformatf("all4_err%0d", j), err, 0);
      Req = Req & ~a;
    end

    for (int t = 0; t < 7; t++) begin
      @(negedge Clk);
      never_done = tbl[t].nd;
      ReqNum[tbl[t].idx*W +: W] = W'(tbl[t].num);
      Req = '0;
      Req[tbl[t].idx] = 1'b1;
      wait_ack(a, res, err, lat);
      Req = '0;
      check($sformatf("vec%0d_ack", t), int'(a), 1 << tbl[t].idx);
      check($sformatf("vec%0d_res", t), res, tbl[t].res);
      check($sformatf("vec%0d_err", t), err, tbl[t].err);
      check($sformatf("vec%0d_lat", t), lat, tbl[t].lat);
      @(negedge Clk);
      check($sformatf("vec%0d_ack_pulse", t), int'(Ack), 0);
      check($sformatf("vec%0d_idle", t), int'(Busy), 0);
      check($sformatf("vec%0d_err_hold", t), int'(RespErr), tbl[t].err);
    end
    never_done = 0;

    // reset in WAIT abandons the job
    eng_lat = 8;
    ReqNum[2*W +: W] = 10'd50;
    Req = 4'b0100;
    @(negedge Clk);
    check("seq_clr_engrst", int'(EngRst), 1);
    check("seq_clr_grant", int'(Grant), 4);
    check("seq_clr_num", int'(EngNumber), 50);
    check("seq_clr_start", int'(EngStart), 0);
    @(negedge Clk);
    check("seq_start_pulse", int'(EngStart), 1);
    check("seq_start_engrst", int'(EngRst), 0);
    @(negedge Clk);
    check("seq_wait_start", int'(EngStart), 0);
    check("seq_wait_busy", int'(Busy), 1);
    @(negedge Clk);
    Rst = 1'b1;
    Req = '0;
    @(negedge Clk);
    check("midrst_ack", int'(Ack), 0);
    check("midrst_grant", int'(Grant), 0);
    check("midrst_busy", int'(Busy), 0);
    check("midrst_start", int'(EngStart), 0);
    check("midrst_num", int'(EngNumber), 0);
    check("midrst_result", int'(RespResult), 0);
    check("midrst_engrst", int'(EngRst), 1);
    Rst = 1'b0;
    nack = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Ack != '0) nack++;
    end
    check("midrst_no_ack", nack, 0);
    eng_lat = 3;
    ReqNum[1*W +: W] = 10'd20;
    Req = 4'b0010;
    wait_ack(a, res, err, lat);
    Req = '0;
    check("after_rst_ack", int'(a), 2);
    check("after_rst_res", res, 13);
    check("after_rst_err", err, 0);

    // requester 2 holds, requester 0 comes and goes
    @(negedge Clk);
    ReqNum[0 +: W] = 10'd30;
    ReqNum[2*W +: W] = 10'd7;
    Req = 4'b0101;
    for (int j = 0; j < 6; j++) begin
      wait_ack(a, res, err, lat);
      check($sformatf("alt_ack%0d", j), int'(a), 1 << exp_c[j]);
      check($sformatf("alt_res%0d", j), res, exp_c[j] == 0 ? 21 : 5);
      Req[0] = (a == 4'b0001) ? 1'b0 : 1'b1;
    end
    Req = '0;
    repeat (10) @(negedge Clk);
    check("final_idle", int'(Busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
